// File: rtl/mux_port_arbiter.sv
// mux_port_arbiter: round-robin arbiter sharing one 4-to-1 data mux between four requesters.
// Define ARBITER_TIMEOUT_EN to build the MaxHold watchdog that preempts long-holding owners.
module mux_port_arbiter #(
  parameter int NBits = 32,
  parameter int MaxHold = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Request,
  input  logic [NBits-1:0] Data0,
  input  logic [NBits-1:0] Data1,
  input  logic [NBits-1:0] Data2,
  input  logic [NBits-1:0] Data3,
  output logic [3:0]       Grant,
  output logic [1:0]       Selector,
  output logic [NBits-1:0] Data_Out,
  output logic             Busy,
  output logic             Timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t state, state_d;
  logic [3:0] grant_d;
  logic [1:0] sel_d, ptr, ptr_d, winner;
  logic expire;
  if (MaxHold < 2) begin : g_bad_hold
    $error("MaxHold must be at least 2");
  end
`ifdef ARBITER_TIMEOUT_EN
  localparam int HW = $clog2(MaxHold);
  logic [HW-1:0] hold;
  assign expire = hold == HW'(MaxHold - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
      Timeout <= 1'b0;
    end else begin
      hold <= (state == GRANT) ? hold + 1'b1 : '0;
      Timeout <= (state == GRANT) && Request[Selector] && expire;
    end
  end
`else
  assign expire = 1'b0;
  assign Timeout = 1'b0;
`endif
  // Scan from ptr+3 down to ptr so the nearest set bit after the pointer wins.
  always_comb begin
    winner = ptr;
    for (int i = 3; i >= 0; i--)
      if (Request[ptr + 2'(i)]) winner = ptr + 2'(i);
  end
  always_comb begin
    state_d = state;
    grant_d = Grant;
    sel_d = Selector;
    ptr_d = ptr;
    if (state == GRANT) begin
      if (!Request[Selector] || expire) begin
        state_d = TURN;
        grant_d = '0;
        ptr_d = Selector + 2'd1;
      end
    end else begin
      state_d = |Request ? GRANT : IDLE;
      grant_d = |Request ? 4'b0001 << winner : 4'b0000;
      sel_d = |Request ? winner : Selector;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      Grant <= '0;
      Selector <= '0;
      ptr <= '0;
    end else begin
      state <= state_d;
      Grant <= grant_d;
      Selector <= sel_d;
      ptr <= ptr_d;
    end
  end
  assign Busy = state == GRANT;
  assign Data_Out = Selector[1] ? (Selector[0] ? Data3 : Data2) : (Selector[0] ? Data1 : Data0);
endmodule
